// File: rtl/idle_pkg.sv
`default_nettype none
// ============================================================================
// Module   : idle_pkg
// Brief    : Shared state encoding and counter widths for the IDLE sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package idle_pkg;

    localparam int IDLE_DRAIN_W  = 16;
    localparam int IDLE_SETTLE_W = 4;
    localparam int IDLE_CNT_W    = 32;

    typedef enum logic [1:0] {
        IDLE_RUN   = 2'd0,
        IDLE_DRAIN = 2'd1,
        IDLE_SLEEP = 2'd2,
        IDLE_WAKE  = 2'd3
    } idle_state_e;

endpackage : idle_pkg
`default_nettype wire

// File: rtl/idle_cnt.sv
`default_nettype none
// ============================================================================
// Module   : idle_cnt
// Brief    : Loadable up-counter; saturates at all-ones, or wraps when WRAP=1.
// Revision : 1.0 - initial release
// ============================================================================
module idle_cnt #(
    parameter int WIDTH = 16,
    parameter bit WRAP  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic             w_hold;

    generate
        if (WRAP) begin : g_wrap
            assign w_hold = 1'b0;
        end else begin : g_sat
            assign w_hold = &r_count;
        end
    endgenerate

    // Clear beats load beats increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_inc && !w_hold) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;

endmodule : idle_cnt
`default_nettype wire

// File: rtl/idle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : idle_ctrl
// Brief    : IDLE instruction sequencer: stall fetch, drain, gate the core
//            clock until an interrupt, then restore clock and release fetch.
//            Define IDLE_CTRL_CNT_EN to add the sleep_cycles counter port.
// Revision : 1.0 - initial release
// ============================================================================
module idle_ctrl
    import idle_pkg::*;
#(
    parameter int WAKE_DELAY = 2,
    parameter int DRAIN_MAX  = 255
) (
    input  logic                  aclk,
    input  logic                  reset,
    input  logic                  idle_req,
    input  logic                  pipe_empty,
    input  logic                  bus_busy,
    input  logic                  irq_pending,
    output logic                  stall_fetch,
    output logic                  block_clock,
    output logic                  idle_over,
    output logic                  drain_timeout,
    output logic                  idle_busy
`ifdef IDLE_CTRL_CNT_EN
    ,
    output logic [IDLE_CNT_W-1:0] sleep_cycles
`endif
);

    // Counters start at 0 on entry, so the exit condition is "last count".
    localparam logic [IDLE_DRAIN_W-1:0]  c_drain_last  = IDLE_DRAIN_W'(DRAIN_MAX - 1);
    localparam logic [IDLE_SETTLE_W-1:0] c_settle_last = IDLE_SETTLE_W'(WAKE_DELAY - 1);

    idle_state_e               r_state;
    idle_state_e               w_state_nxt;
    logic                      w_over_nxt;
    logic                      w_to_nxt;

    logic                      r_stall;
    logic                      r_block;
    logic                      r_over;
    logic                      r_to;
    logic                      r_busy;

    logic                      w_drain_clr;
    logic                      w_drain_inc;
    logic                      w_settle_clr;
    logic                      w_settle_inc;
    logic [IDLE_DRAIN_W-1:0]   w_drain_cnt;
    logic [IDLE_SETTLE_W-1:0]  w_settle_cnt;

    assign w_drain_clr  = (r_state == IDLE_RUN) && idle_req;
    assign w_drain_inc  = (r_state == IDLE_DRAIN);
    assign w_settle_clr = (w_state_nxt == IDLE_WAKE) && (r_state != IDLE_WAKE);
    assign w_settle_inc = (r_state == IDLE_WAKE);

    idle_cnt #(
        .WIDTH (IDLE_DRAIN_W),
        .WRAP  (1'b0)
    ) u_drain_cnt (
        .clk        (aclk),
        .rst        (reset),
        .i_clr      (w_drain_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_drain_inc),
        .o_count    (w_drain_cnt)
    );

    idle_cnt #(
        .WIDTH (IDLE_SETTLE_W),
        .WRAP  (1'b0)
    ) u_settle_cnt (
        .clk        (aclk),
        .rst        (reset),
        .i_clr      (w_settle_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_settle_inc),
        .o_count    (w_settle_cnt)
    );

    // Interrupt outranks drain completion, which outranks the drain timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_over_nxt  = 1'b0;
        w_to_nxt    = 1'b0;
        case (r_state)
            IDLE_RUN: begin
                if (idle_req) begin
                    w_state_nxt = IDLE_DRAIN;
                end
            end
            IDLE_DRAIN: begin
                if (irq_pending) begin
                    w_state_nxt = IDLE_WAKE;
                    w_over_nxt  = 1'b1;
                end else if (pipe_empty && !bus_busy) begin
                    w_state_nxt = IDLE_SLEEP;
                end else if (w_drain_cnt >= c_drain_last) begin
                    w_state_nxt = IDLE_WAKE;
                    w_to_nxt    = 1'b1;
                end
            end
            IDLE_SLEEP: begin
                if (irq_pending) begin
                    w_state_nxt = IDLE_WAKE;
                    w_over_nxt  = 1'b1;
                end
            end
            IDLE_WAKE: begin
                if (w_settle_cnt >= c_settle_last) begin
                    w_state_nxt = IDLE_RUN;
                end
            end
            default: begin
                w_state_nxt = IDLE_RUN;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with it.
    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state <= IDLE_RUN;
            r_stall <= 1'b0;
            r_block <= 1'b0;
            r_over  <= 1'b0;
            r_to    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_stall <= (w_state_nxt != IDLE_RUN);
            r_block <= (w_state_nxt == IDLE_SLEEP);
            r_over  <= w_over_nxt;
            r_to    <= w_to_nxt;
            r_busy  <= (w_state_nxt != IDLE_RUN);
        end
    end

    assign stall_fetch   = r_stall;
    assign block_clock   = r_block;
    assign idle_over     = r_over;
    assign drain_timeout = r_to;
    assign idle_busy     = r_busy;

`ifdef IDLE_CTRL_CNT_EN
    idle_cnt #(
        .WIDTH (IDLE_CNT_W),
        .WRAP  (1'b1)
    ) u_sleep_cnt (
        .clk        (aclk),
        .rst        (reset),
        .i_clr      (1'b0),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (r_state == IDLE_SLEEP),
        .o_count    (sleep_cycles)
    );
`endif

endmodule : idle_ctrl
`default_nettype wire

// File: tb/tb_idle_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_idle_ctrl
// Brief    : Self-checking bench for idle_ctrl; two instances (default drain
//            limit and a short one) checked against an episode-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idle_ctrl;

    localparam int WD_A = 2;
    localparam int DM_A = 255;
    localparam int WD_B = 3;
    localparam int DM_B = 8;

    logic aclk = 1'b0;
    logic reset, idle_req, pipe_empty, bus_busy, irq_pending;
    logic stall_a, block_a, over_a, to_a, busy_a;
    logic stall_b, block_b, over_b, to_b, busy_b;
`ifdef IDLE_CTRL_CNT_EN
    logic [31:0] sc_a, sc_b;
`endif

    always #5 aclk = ~aclk;

    idle_ctrl #(.WAKE_DELAY(WD_A), .DRAIN_MAX(DM_A)) u_dut_a (
        .aclk          (aclk),
        .reset         (reset),
        .idle_req      (idle_req),
        .pipe_empty    (pipe_empty),
        .bus_busy      (bus_busy),
        .irq_pending   (irq_pending),
        .stall_fetch   (stall_a),
        .block_clock   (block_a),
        .idle_over     (over_a),
        .drain_timeout (to_a),
        .idle_busy     (busy_a)
`ifdef IDLE_CTRL_CNT_EN
        ,
        .sleep_cycles  (sc_a)
`endif
    );

    idle_ctrl #(.WAKE_DELAY(WD_B), .DRAIN_MAX(DM_B)) u_dut_b (
        .aclk          (aclk),
        .reset         (reset),
        .idle_req      (idle_req),
        .pipe_empty    (pipe_empty),
        .bus_busy      (bus_busy),
        .irq_pending   (irq_pending),
        .stall_fetch   (stall_b),
        .block_clock   (block_b),
        .idle_over     (over_b),
        .drain_timeout (to_b),
        .idle_busy     (busy_b)
`ifdef IDLE_CTRL_CNT_EN
        ,
        .sleep_cycles  (sc_b)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Episode model: drain age since request, asleep flag, wake countdown.
    int m_wd [2];
    int m_dm [2];
    int drain_age [2];
    bit asleep [2];
    int wake_left [2];
    bit m_over [2];
    bit m_to [2];
`ifdef IDLE_CTRL_CNT_EN
    logic [31:0] m_sc [2];
`endif

    function automatic void model_init();
        m_wd[0] = WD_A; m_dm[0] = DM_A;
        m_wd[1] = WD_B; m_dm[1] = DM_B;
        for (int i = 0; i < 2; i++) begin
            drain_age[i] = -1; asleep[i] = 1'b0; wake_left[i] = 0;
            m_over[i] = 1'b0; m_to[i] = 1'b0;
`ifdef IDLE_CTRL_CNT_EN
            m_sc[i] = '0;
`endif
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            m_over[i] = 1'b0;
            m_to[i]   = 1'b0;
            if (reset) begin
                drain_age[i] = -1; asleep[i] = 1'b0; wake_left[i] = 0;
`ifdef IDLE_CTRL_CNT_EN
                m_sc[i] = '0;
`endif
            end else begin
`ifdef IDLE_CTRL_CNT_EN
                if (asleep[i]) m_sc[i] = m_sc[i] + 32'd1;
`endif
                if (wake_left[i] > 0) begin
                    wake_left[i] = wake_left[i] - 1;
                end else if (asleep[i]) begin
                    if (irq_pending) begin
                        asleep[i] = 1'b0; wake_left[i] = m_wd[i]; m_over[i] = 1'b1;
                    end
                end else if (drain_age[i] >= 0) begin
                    drain_age[i] = drain_age[i] + 1;
                    if (irq_pending) begin
                        drain_age[i] = -1; wake_left[i] = m_wd[i]; m_over[i] = 1'b1;
                    end else if (pipe_empty && !bus_busy) begin
                        drain_age[i] = -1; asleep[i] = 1'b1;
                    end else if (drain_age[i] >= m_dm[i]) begin
                        drain_age[i] = -1; wake_left[i] = m_wd[i]; m_to[i] = 1'b1;
                    end
                end else if (idle_req) begin
                    drain_age[i] = 0;
                end
            end
        end
    endfunction

    // {stall_fetch, block_clock, idle_over, drain_timeout, idle_busy}
    function automatic logic [4:0] exp_out(int i);
        logic act;
        act = (drain_age[i] >= 0) || asleep[i] || (wake_left[i] > 0);
        return {act, asleep[i], m_over[i], m_to[i], act};
    endfunction

    function automatic logic [4:0] act_out(int i);
        if (i == 0) return {stall_a, block_a, over_a, to_a, busy_a};
        return {stall_b, block_b, over_b, to_b, busy_b};
    endfunction

    task automatic tick();
        @(posedge aclk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; idle_req = 1'b0; irq_pending = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; idle_req = 1'b1; pipe_empty = 1'b1; bus_busy = 1'b0; irq_pending = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_out(i) !== 5'b0) begin
                errors++;
                $display("FAIL reset_outputs inst=%0d got=%b want=%b", i, act_out(i), 5'b0);
            end
        end
        reset = 1'b0; idle_req = 1'b0;
        tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act_out(i) !== 5'b0) begin
                errors++;
                $display("FAIL reset_req_ignored inst=%0d got=%b want=%b", i, act_out(i), 5'b0);
            end
        end
    endtask

    task automatic test_drained();
        int n;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            idle_req = (c == 10); irq_pending = (c >= 20); pipe_empty = 1'b1; bus_busy = 1'b0;
            tick();
            n = c + 1;
            checks++;
            if (block_a !== (n >= 12 && n <= 20)) begin
                errors++;
                $display("FAIL drained_block n=%0d got=%b want=%b", n, block_a, (n >= 12 && n <= 20));
            end
            checks++;
            if (over_a !== (n == 21)) begin
                errors++;
                $display("FAIL drained_over n=%0d got=%b want=%b", n, over_a, (n == 21));
            end
            checks++;
            if (stall_a !== (n >= 11 && n <= 22)) begin
                errors++;
                $display("FAIL drained_stall n=%0d got=%b want=%b", n, stall_a, (n >= 11 && n <= 22));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL drained_model inst=%0d n=%0d got=%b want=%b", i, n, act_out(i), exp_out(i));
                end
            end
        end
        irq_pending = 1'b0;
    endtask

    task automatic test_slow_drain();
        int n, s;
        do_reset();
        s = 5 + int'($urandom_range(0, 3));
        for (int c = 0; c <= s + 45; c++) begin
            idle_req = (c == s); bus_busy = (c >= s && c <= s + 30);
            pipe_empty = 1'b1; irq_pending = (c == s + 40);
            tick();
            n = c + 1;
            checks++;
            if (block_a !== (n >= s + 32 && n <= s + 40)) begin
                errors++;
                $display("FAIL slow_block n=%0d got=%b want=%b", n - s, block_a, (n >= s + 32 && n <= s + 40));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL slow_model inst=%0d n=%0d got=%b want=%b", i, n - s, act_out(i), exp_out(i));
                end
            end
        end
    endtask

    task automatic test_irq_in_drain();
        int n, s, d, k;
        do_reset();
        s = 3 + int'($urandom_range(0, 3));
        d = 1 + int'($urandom_range(0, 4));
        k = s + d + 1;
        for (int c = 0; c <= s + d + 10; c++) begin
            idle_req = (c == s); pipe_empty = (c >= s + d); bus_busy = (c < s + d);
            irq_pending = (c == s + d);
            tick();
            n = c + 1;
            checks++;
            if (block_a !== 1'b0) begin
                errors++;
                $display("FAIL irqdrain_block n=%0d got=%b want=0", n, block_a);
            end
            checks++;
            if (over_a !== (n == k)) begin
                errors++;
                $display("FAIL irqdrain_over n=%0d got=%b want=%b", n, over_a, (n == k));
            end
            checks++;
            if (busy_a !== (n >= s + 1 && n < k + WD_A)) begin
                errors++;
                $display("FAIL irqdrain_busy n=%0d got=%b want=%b", n, busy_a, (n >= s + 1 && n < k + WD_A));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL irqdrain_model inst=%0d n=%0d got=%b want=%b", i, n, act_out(i), exp_out(i));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n, s;
        do_reset();
        s = 4;
        for (int c = 0; c <= s + 20; c++) begin
            idle_req = (c == s); bus_busy = 1'b1; pipe_empty = 1'(($urandom & 1));
            irq_pending = 1'b0;
            tick();
            n = c + 1;
            checks++;
            if (to_b !== (n == s + 1 + DM_B)) begin
                errors++;
                $display("FAIL timeout_pulse n=%0d got=%b want=%b", n, to_b, (n == s + 1 + DM_B));
            end
            checks++;
            if (over_b !== 1'b0) begin
                errors++;
                $display("FAIL timeout_no_over n=%0d got=%b want=0", n, over_b);
            end
            checks++;
            if (busy_b !== (n >= s + 1 && n < s + 1 + DM_B + WD_B)) begin
                errors++;
                $display("FAIL timeout_busy n=%0d got=%b want=%b", n, busy_b, (n >= s + 1 && n < s + 1 + DM_B + WD_B));
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL timeout_model inst=%0d n=%0d got=%b want=%b", i, n, act_out(i), exp_out(i));
                end
            end
        end
    endtask

    task automatic test_reset_in_sleep();
        int n;
        for (int c = 0; c <= 25; c++) begin
            reset = (c == 0 || c == 8); idle_req = (c == 3 || c == 8 || c == 12);
            pipe_empty = 1'b1; bus_busy = 1'b0; irq_pending = (c == 18);
            tick();
            n = c + 1;
            if (n == 9) begin
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (act_out(i) !== 5'b0) begin
                        errors++;
                        $display("FAIL sleep_reset inst=%0d got=%b want=%b", i, act_out(i), 5'b0);
                    end
                end
            end
            if (n == 13) begin
                checks++;
                if ({stall_a, block_a} !== 2'b10) begin
                    errors++;
                    $display("FAIL rereq_drain got=%b want=10", {stall_a, block_a});
                end
            end
            if (n == 14) begin
                checks++;
                if (block_a !== 1'b1) begin
                    errors++;
                    $display("FAIL rereq_sleep got=%b want=1", block_a);
                end
            end
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL sleepreset_model inst=%0d n=%0d got=%b want=%b", i, n, act_out(i), exp_out(i));
                end
            end
        end
    endtask

    task automatic test_random();
        int bus_pct;
        bus_pct = 30;
        for (int c = 0; c < 1500; c++) begin
            if (c % 100 == 0) bus_pct = (c / 100) % 3 == 0 ? 10 : ((c / 100) % 3 == 1 ? 50 : 97);
            reset       = ($urandom_range(0, 199) == 0);
            idle_req    = ($urandom_range(0, 7) == 0);
            pipe_empty  = ($urandom_range(0, 3) != 0);
            bus_busy    = (int'($urandom_range(0, 99)) < bus_pct);
            irq_pending = ($urandom_range(0, 19) == 0);
            tick();
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act_out(i) !== exp_out(i)) begin
                    errors++;
                    $display("FAIL random_model inst=%0d cyc=%0d got=%b want=%b", i, c, act_out(i), exp_out(i));
                end
            end
        end
        reset = 1'b0; idle_req = 1'b0; irq_pending = 1'b0;
    endtask

`ifdef IDLE_CTRL_CNT_EN
    task automatic test_sleep_count();
        bit ok;
        do_reset();
        pipe_empty = 1'b1; bus_busy = 1'b0;
        for (int rep = 0; rep < 2; rep++) begin
            idle_req = 1'b1;
            tick();
            idle_req = 1'b0;
            ok = 1'b0;
            for (int w = 0; w < 10 && !ok; w++) begin
                tick();
                ok = (block_a === 1'b1);
            end
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL cnt_sleep_entry rep=%0d got=%b want=1", rep, block_a);
            end
            for (int w = 0; w < 99; w++) tick();
            irq_pending = 1'b1;
            tick();
            irq_pending = 1'b0;
            for (int w = 0; w < 10; w++) tick();
        end
        checks++;
        if (sc_a !== 32'd200) begin
            errors++;
            $display("FAIL cnt_total got=%0d want=200", sc_a);
        end
        checks++;
        if (sc_b !== m_sc[1]) begin
            errors++;
            $display("FAIL cnt_model_b got=%0d want=%0d", sc_b, m_sc[1]);
        end
    endtask
`endif

    initial begin
        reset = 1'b1; idle_req = 1'b0; pipe_empty = 1'b1; bus_busy = 1'b0; irq_pending = 1'b0;
        model_init();
        test_reset();
        test_drained();
        test_slow_drain();
        test_irq_in_drain();
        test_timeout();
        test_reset_in_sleep();
        test_random();
`ifdef IDLE_CTRL_CNT_EN
        test_sleep_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_expired time=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_idle_ctrl
`default_nettype wire

// File: doc/idle_ctrl.md
# idle_ctrl

Sequencer for the LoongArch IDLE instruction. Runs on the free-running `aclk` and drives the core clock-gating block's `block_clock` / `idle_over` inputs. On each idle request it:
- stalls fetch,
- waits for the pipeline and bus interfaces to drain,
- gates the core clock until an enabled interrupt is pending,
- then restores the clock and releases fetch after a fixed settle delay.

## Interface
Parameters:
- `WAKE_DELAY`, default 2: cycles between clock restore and fetch release; legal range 1..15.
- `DRAIN_MAX`, default 255: maximum cycles spent in DRAIN before abort; legal range 1..65535.

Ports (`aclk` is never gated):
- `aclk` in 1: free-running system clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `idle_req` in 1: one-cycle pulse when an IDLE instruction commits.
- `pipe_empty` in 1: no valid instruction beyond fetch.
- `bus_busy` in 1: AXI read/write outstanding, or a cache refill/writeback is in progress.
- `irq_pending` in 1: OR of (ESTAT.IS & ECFG.LIE); level, asynchronous to IDLE.
- `stall_fetch` out 1: holds IF; high from DRAIN through WAKE.
- `block_clock` out 1: to the clock gate; high only in SLEEP.
- `idle_over` out 1: one-cycle pulse when wake-up starts.
- `drain_timeout` out 1: one-cycle pulse when DRAIN aborts.
- `idle_busy` out 1: state != RUN.
- `sleep_cycles` out 32: present only with `IDLE_CTRL_CNT_EN`.

## Operation
- States: RUN, DRAIN, SLEEP, WAKE; encoding is 2-bit binary.
- All outputs are registered.
- **RUN**
  - `idle_req` → DRAIN.
  - `idle_req` in any other state is ignored; no queuing.
- **DRAIN**
  - A drain counter counts from 0.
  - Priority order:
    1. `irq_pending` → WAKE with an `idle_over` pulse; SLEEP is skipped.
    2. `pipe_empty & ~bus_busy` → SLEEP.
    3. Counter reaches `DRAIN_MAX` → WAKE with a `drain_timeout` pulse and no `idle_over`.
- **SLEEP**
  - `block_clock`=1.
  - `irq_pending` → WAKE with an `idle_over` pulse.
  - `bus_busy` / `pipe_empty` are ignored while in SLEEP.
- **WAKE**
  - `block_clock`=0.
  - Settle counter counts `WAKE_DELAY` cycles, then → RUN; `stall_fetch` drops on entry to RUN.
  - `irq_pending` is ignored in WAKE.
- Counters:
  - Drain counter: 16-bit, cleared on DRAIN entry, saturating.
  - Settle counter: 4-bit, cleared on WAKE entry.
- `reset`:
  - Takes effect in any state, including SLEEP: state=RUN, all outputs 0, counters 0.
  - The gate reopens the cycle after reset.

## Timing
- `idle_req` at edge N → DRAIN and `stall_fetch`=1 visible after edge N.
- Drain complete, sampled at edge M → `block_clock`=1 after edge M.
- `irq_pending` sampled high at edge K in SLEEP:
  - `block_clock`=0 and `idle_over`=1 after edge K;
  - `idle_over`=0 after K+1;
  - `stall_fetch`=0 after K+`WAKE_DELAY`.
- Minimum idle episode, with inputs already drained: RUN → DRAIN → SLEEP takes 2 edges after `idle_req`.
- `irq_pending` and drain complete in the same DRAIN cycle: interrupt wins, → WAKE.
- Timeout and drain complete in the same cycle: drain wins, → SLEEP.
- `idle_req` in the same cycle as `reset`: reset wins.

## Configuration
- `IDLE_CTRL_CNT_EN` defined:
  - 32-bit `sleep_cycles` increments on every cycle in SLEEP; wraps at 2^32.
  - Cleared only by `reset`; value is held outside SLEEP.
- Undefined: port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `idle_pkg` holds:
  - the state enum (`IDLE_RUN`=0, `IDLE_DRAIN`=1, `IDLE_SLEEP`=2, `IDLE_WAKE`=3);
  - width constants `IDLE_DRAIN_W`=16, `IDLE_SETTLE_W`=4, `IDLE_CNT_W`=32.
- One sub-module, `idle_cnt`: loadable, saturating up-counter. Instantiated twice (drain, settle), plus a third time for `sleep_cycles` under the macro, configured to wrap.
- The FSM and output registers live in the top module.

## Test plan
- Drained core:
  - Stimulus: `pipe_empty`=1, `bus_busy`=0, `idle_req` at cycle 10, `irq_pending` at cycle 20.
  - Required: `block_clock` high during cycles 12–20, `idle_over` pulse at 21, `stall_fetch` low from 23.
- Slow drain:
  - Stimulus: `bus_busy` held high 30 cycles after `idle_req`.
  - Required: SLEEP entered exactly 1 cycle after `bus_busy` falls; no `block_clock` before that.
- Interrupt during drain:
  - Stimulus: `irq_pending` raised in DRAIN, same cycle as `pipe_empty` rises.
  - Required: `block_clock` never asserted; `idle_over` pulse; RUN after `WAKE_DELAY`.
- Timeout:
  - Stimulus: `DRAIN_MAX`=8, `bus_busy` stuck at 1.
  - Required: `drain_timeout` pulse 8 cycles after DRAIN entry, no `idle_over`, back in RUN.
- Reset in SLEEP:
  - Stimulus: assert `reset` for 1 cycle while in SLEEP.
  - Required: all outputs 0 next cycle; a new `idle_req` is accepted normally.
- `IDLE_CTRL_CNT_EN`:
  - Stimulus: 100 cycles in SLEEP, twice.
  - Required: `sleep_cycles`=200; a preloaded value of 2^32−1 wraps to 0.
